// File: rtl/pulse_measure.sv
// Measures rise-to-rise period and high width of pulse_in in clk cycles; flags a sticky timeout.
// Results appear with a one-cycle meas_valid the cycle after the closing rise is sampled; no backpressure.
module pulse_measure #(
   parameter int CNT_WIDTH  = 16,
   parameter int TIMEOUT    = 1000,
   parameter int MCNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  pulse_in,
   output logic [CNT_WIDTH-1:0]  period,
   output logic [CNT_WIDTH-1:0]  width,
   output logic                  meas_valid,
   output logic                  timeout,
   output logic [MCNT_WIDTH-1:0] meas_count
);

   typedef enum logic {IDLE, ARMED} state_t;

   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_LIM  = CNT_WIDTH'(TIMEOUT);
   localparam logic [MCNT_WIDTH-1:0] MCNT_ONE = MCNT_WIDTH'(1);

   state_t               state;
   logic                 pulse_q;
   logic [CNT_WIDTH-1:0] per_cnt;
   logic [CNT_WIDTH-1:0] wid_cnt;
   logic                 wid_run;
   logic                 rise;

   // pulse_q clears in reset, so a high input right after release counts as a rise
   assign rise = pulse_in & ~pulse_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         pulse_q    <= 1'b0;
         per_cnt    <= '0;
         wid_cnt    <= '0;
         wid_run    <= 1'b0;
         period     <= '0;
         width      <= '0;
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
         meas_count <= '0;
      end else begin
         pulse_q    <= pulse_in;
         meas_valid <= 1'b0;
         if (!ena) begin
            state   <= IDLE;
            per_cnt <= '0;
            wid_cnt <= '0;
            wid_run <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (rise) begin
                     per_cnt <= CNT_ONE;
                     wid_cnt <= CNT_ONE;
                     wid_run <= 1'b1;
                     timeout <= 1'b0;
                     state   <= ARMED;
                  end
               end
               ARMED: begin
                  // a rise landing on the timeout cycle still closes a valid period
                  if (rise) begin
                     period     <= per_cnt;
                     width      <= wid_cnt;
                     meas_valid <= 1'b1;
                     meas_count <= meas_count + MCNT_ONE;
                     per_cnt    <= CNT_ONE;
                     wid_cnt    <= CNT_ONE;
                     wid_run    <= 1'b1;
                  end else if (per_cnt == CNT_LIM) begin
                     timeout <= 1'b1;
                     state   <= IDLE;
                     per_cnt <= '0;
                     wid_cnt <= '0;
                     wid_run <= 1'b0;
                  end else begin
                     per_cnt <= per_cnt + CNT_ONE;
                     if (wid_run && pulse_in)
                        wid_cnt <= wid_cnt + CNT_ONE;
                     if (!pulse_in)
                        wid_run <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
